// File: rtl/arm_imm_pkg.sv
// Shared types and constants for the ARM operand-2 immediate encoder.
// Build option: ARM_IMM_MVN_EN adds the inverted (MVN) search path.
package arm_imm_pkg;
  localparam int DATA_W   = 32;
  localparam int IMM_W    = 8;
  localparam int ROT_W    = 4;
  localparam int ROT_STEP = 2;
  localparam int SHAMT_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  typedef struct packed {
    logic             found;
    logic [ROT_W-1:0] rot;
    logic [IMM_W-1:0] imm8;
    logic             inv;
  } result_t;
endpackage

// File: rtl/imm_rotl.sv
// Combinational 32-bit rotate-left; zero amount passes data through unchanged.
module imm_rotl
  import arm_imm_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amt,
  output logic [DATA_W-1:0]  result
);
  logic [SHAMT_W:0] rsh;

  // A right shift by the full width yields zero, which is what amt==0 needs.
  assign rsh    = (SHAMT_W + 1)'(DATA_W) - {1'b0, amt};
  assign result = (data << amt) | (data >> rsh);
endmodule

// File: rtl/arm_imm_encoder.sv
// Iterative (rot, imm8) search for a 32-bit constant, one rotation per clock, smallest rot wins.
// Build option: ARM_IMM_MVN_EN also tests ~value each cycle (direct form has priority).
module arm_imm_encoder
  import arm_imm_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_found,
  output logic [ROT_W-1:0]  out_rot,
  output logic [IMM_W-1:0]  out_imm8,
  output logic              out_inv
);
  state_t            state_q, state_d;
  logic [ROT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] value_q, value_d;
  result_t           res_q, res_d;

  logic [SHAMT_W-1:0] amt;
  logic [DATA_W-1:0]  cand;
  logic               direct_hit;

  assign amt = {cnt_q, 1'b0};

  imm_rotl u_rotl_direct (
    .data   (value_q),
    .amt    (amt),
    .result (cand)
  );

  assign direct_hit = (cand[DATA_W-1:IMM_W] == '0);

`ifdef ARM_IMM_MVN_EN
  logic [DATA_W-1:0] cand_inv;
  logic              inv_hit;

  imm_rotl u_rotl_inv (
    .data   (~value_q),
    .amt    (amt),
    .result (cand_inv)
  );

  assign inv_hit = (cand_inv[DATA_W-1:IMM_W] == '0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      value_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          value_d = in_value;
          cnt_d   = '0;
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (direct_hit) begin
          res_d   = '{found: 1'b1, rot: cnt_q, imm8: cand[IMM_W-1:0], inv: 1'b0};
          state_d = DONE;
`ifdef ARM_IMM_MVN_EN
        end else if (inv_hit) begin
          res_d   = '{found: 1'b1, rot: cnt_q, imm8: cand_inv[IMM_W-1:0], inv: 1'b1};
          state_d = DONE;
`endif
        end else if (cnt_q == {ROT_W{1'b1}}) begin
          res_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        // Result fields are cleared on hand-off so stale data never lingers.
        if (out_ready) begin
          res_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_found = res_q.found;
  assign out_rot   = res_q.rot;
  assign out_imm8  = res_q.imm8;
  assign out_inv   = res_q.inv;
endmodule

// File: tb/tb_arm_imm_encoder.sv
// Directed-vector bench for arm_imm_encoder with a brute-force reference search model.
module tb_arm_imm_encoder;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_found;
  logic [3:0]  out_rot;
  logic [7:0]  out_imm8;
  logic        out_inv;

  int n_chk  = 0;
  int n_fail = 0;

  arm_imm_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_found (out_found),
    .out_rot   (out_rot),
    .out_imm8  (out_imm8),
    .out_inv   (out_inv)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  // Reference: exhaustively try every (rot, imm8) pair, smallest rot first.
  function automatic logic [13:0] model(input logic [31:0] v);
    for (int r = 0; r < 16; r++) begin
      for (int imm = 0; imm < 256; imm++)
        if (ror32(32'(imm), 2 * r) == v) return {1'b1, 4'(r), 8'(imm), 1'b0};
`ifdef ARM_IMM_MVN_EN
      for (int imm = 0; imm < 256; imm++)
        if (ror32(32'(imm), 2 * r) == ~v) return {1'b1, 4'(r), 8'(imm), 1'b1};
`endif
    end
    return 14'd0;
  endfunction

  logic [13:0] mdl_exp;
  logic        mdl_pending = 1'b0;

  // Scoreboard: capture on accept, check DUT on every cycle a result is presented.
  always @(negedge clk) begin
    if (!reset_n) begin
      mdl_pending <= 1'b0;
    end else begin
      if (out_valid) begin
        chk("sb_pending", 32'(mdl_pending), 32'd1);
        chk("sb_result", {18'd0, out_found, out_rot, out_imm8, out_inv}, {18'd0, mdl_exp});
        chk("sb_in_ready_busy", 32'(in_ready), 32'd0);
        if (out_ready) mdl_pending <= 1'b0;
      end
      if (in_valid && in_ready) begin
        mdl_exp     <= model(in_value);
        mdl_pending <= 1'b1;
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic run_req(input logic [31:0] v, input logic e_found, input logic [3:0] e_rot,
                         input logic [7:0] e_imm, input logic e_inv, input int e_lat,
                         input int hold, input bit junk);
    int lat = 0;
    wait_ready();
    in_value = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (junk) in_value = 32'hDEADBEEF;
    else in_valid = 1'b0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    chk($sformatf("lat_%h", v), 32'(lat), 32'(e_lat));
    chk($sformatf("res_%h", v), {18'd0, out_found, out_rot, out_imm8, out_inv},
        {18'd0, e_found, e_rot, e_imm, e_inv});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_res", {18'd0, out_found, out_rot, out_imm8, out_inv},
          {18'd0, e_found, e_rot, e_imm, e_inv});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("consume_valid", 32'(out_valid), 32'd0);
    chk("consume_in_ready", 32'(in_ready), 32'd1);
    chk("consume_zeroed", {19'd0, out_found, out_rot, out_imm8}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_outputs", {18'd0, out_valid, out_found, out_rot, out_imm8, out_inv}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);

    run_req(32'h000000FF, 1'b1, 4'd0,  8'hFF, 1'b0, 1,  0, 1'b0);
    run_req(32'hFF000000, 1'b1, 4'd4,  8'hFF, 1'b0, 5,  0, 1'b1);
    run_req(32'hC000003F, 1'b1, 4'd1,  8'hFF, 1'b0, 2,  0, 1'b0);
    run_req(32'h00000102, 1'b0, 4'd0,  8'h00, 1'b0, 16, 0, 1'b0);
    run_req(32'h000003FC, 1'b1, 4'd15, 8'hFF, 1'b0, 16, 0, 1'b0);
    run_req(32'h00AB0000, 1'b1, 4'd8,  8'hAB, 1'b0, 9,  1, 1'b1);
    run_req(32'h12345678, 1'b0, 4'd0,  8'h00, 1'b0, 16, 0, 1'b0);
    run_req(32'h00000000, 1'b1, 4'd0,  8'h00, 1'b0, 1,  3, 1'b0);
`ifdef ARM_IMM_MVN_EN
    run_req(32'hFFFFFF00, 1'b1, 4'd0,  8'hFF, 1'b1, 1,  0, 1'b0);
`else
    run_req(32'hFFFFFF00, 1'b0, 4'd0,  8'h00, 1'b0, 16, 0, 1'b0);
`endif

    // Reset in the middle of a long search drops the request.
    wait_ready();
    in_value = 32'h00000102;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_outputs", {19'd0, out_found, out_rot, out_imm8}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_dropped", 32'(out_valid), 32'd0);

    run_req(32'hC000003F, 1'b1, 4'd1, 8'hFF, 1'b0, 2, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
